// File: rtl/cache_pkg.sv
// Shared definitions for the data cache: geometry, FSM states and address helpers.
package cache_pkg;

    localparam int LINE_ADDR_LEN = 3;
    localparam int SET_ADDR_LEN  = 4;
    localparam int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
    localparam int NUM_SETS      = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } cacheState_e;

    function automatic logic [LINE_ADDR_LEN-1:0] getOffset(input logic [31:0] a);
        return a[LINE_ADDR_LEN+1:2];
    endfunction

    function automatic logic [SET_ADDR_LEN-1:0] getSet(input logic [31:0] a);
        return a[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    endfunction

    function automatic logic [TAG_ADDR_LEN-1:0] getTag(input logic [31:0] a);
        return a[31:32-TAG_ADDR_LEN];
    endfunction

    // Word-aligned memory address of one beat of a line
    function automatic logic [31:0] beatAddr(input logic [TAG_ADDR_LEN-1:0] tag,
                                             input logic [SET_ADDR_LEN-1:0] set,
                                             input logic [LINE_ADDR_LEN-1:0] beat);
        return {tag, set, beat, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line data array: one byte-enabled write port, a CPU read port and a write-back read port.
module dcache_line_store
    import cache_pkg::*;
(
    input  logic                     clk,
    input  logic [3:0]               wrEn,
    input  logic [SET_ADDR_LEN-1:0]  wrSet,
    input  logic [LINE_ADDR_LEN-1:0] wrWord,
    input  logic [31:0]              wrData,
    input  logic [SET_ADDR_LEN-1:0]  rdSet,
    input  logic [LINE_ADDR_LEN-1:0] rdWord,
    output logic [31:0]              rdData,
    input  logic [SET_ADDR_LEN-1:0]  wbSet,
    input  logic [LINE_ADDR_LEN-1:0] wbWord,
    output logic [31:0]              wbData
);

    logic [31:0] words [NUM_SETS*LINE_WORDS];

    // Byte-lane write; a fill beat arrives with all four lanes enabled
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wrEn[b]) begin
                words[{wrSet, wrWord}][b*8 +: 8] <= wrData[b*8 +: 8];
            end
        end
    end

    assign rdData = words[{rdSet, rdWord}];
    assign wbData = words[{wbSet, wbWord}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a word-wide memory port.
module data_cache
    import cache_pkg::*;
(
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        rd_req,
    input  logic [3:0]  wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    cacheState_e              state;
    logic [NUM_SETS-1:0]      validBits;
    logic [NUM_SETS-1:0]      dirtyBits;
    logic [TAG_ADDR_LEN-1:0]  tagArray [NUM_SETS];
    logic [LINE_ADDR_LEN-1:0] beat;
    logic [LINE_ADDR_LEN-1:0] beatNext;
    logic [SET_ADDR_LEN-1:0]  curSet;
    logic [TAG_ADDR_LEN-1:0]  curTag;
    logic [TAG_ADDR_LEN-1:0]  victimTag;

    logic [LINE_ADDR_LEN-1:0] reqOffset;
    logic [SET_ADDR_LEN-1:0]  reqSet;
    logic [TAG_ADDR_LEN-1:0]  reqTag;
    logic                     active;
    logic                     hit;
    logic                     storeHit;
    logic                     beatAck;
    logic                     lastBeat;
    logic                     unusedAddrBits;

    logic [3:0]               storeWrEn;
    logic [SET_ADDR_LEN-1:0]  storeSet;
    logic [LINE_ADDR_LEN-1:0] storeWord;
    logic [31:0]              storeData;
    logic [SET_ADDR_LEN-1:0]  wbSet;
    logic [LINE_ADDR_LEN-1:0] wbWord;
    logic [31:0]              wbData;

    assign reqOffset      = getOffset(addr);
    assign reqSet         = getSet(addr);
    assign reqTag         = getTag(addr);
    assign unusedAddrBits = ^addr[1:0];

    assign active   = rd_req | (|wr_req);
    assign hit      = validBits[reqSet] && (tagArray[reqSet] == reqTag) && (state == IDLE);
    assign storeHit = active && hit && (|wr_req);
    assign miss     = (state != IDLE) || (active && !hit);
    assign beatAck  = mem_req && mem_ack;
    assign lastBeat = (beat == '1);
    assign beatNext = beat + 1'b1;

    // Write-back reads fetch the word for the beat about to be presented
    assign wbSet  = (state == IDLE) ? reqSet : curSet;
    assign wbWord = (state == IDLE) ? '0 : beatNext;

    // Single write port: fill beats take priority, store hits only occur in IDLE
    always_comb begin
        storeWrEn = '0;
        storeSet  = reqSet;
        storeWord = reqOffset;
        storeData = wr_data;
        if (state == FILL && beatAck) begin
            storeWrEn = 4'hF;
            storeSet  = curSet;
            storeWord = beat;
            storeData = mem_rdata;
        end else if (storeHit) begin
            storeWrEn = wr_req;
        end
    end

    dcache_line_store u_lineStore (
        .clk    (CPU_CLK),
        .wrEn   (storeWrEn),
        .wrSet  (storeSet),
        .wrWord (storeWord),
        .wrData (storeData),
        .rdSet  (reqSet),
        .rdWord (reqOffset),
        .rdData (rd_data),
        .wbSet  (wbSet),
        .wbWord (wbWord),
        .wbData (wbData)
    );

    // Tag is written once the last fill beat lands; validity is tracked separately
    always_ff @(posedge CPU_CLK) begin
        if (state == FILL && beatAck && lastBeat) begin
            tagArray[curSet] <= curTag;
        end
    end

    // Miss-handling FSM, line status bits, memory port and statistics
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state      <= IDLE;
            beat       <= '0;
            validBits  <= '0;
            dirtyBits  <= '0;
            curSet     <= '0;
            curTag     <= '0;
            victimTag  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active && hit) begin
                        hit_count <= hit_count + 32'd1;
                        if (|wr_req) begin
                            dirtyBits[reqSet] <= 1'b1;
                        end
                    end else if (active) begin
                        miss_count        <= miss_count + 32'd1;
                        curSet            <= reqSet;
                        curTag            <= reqTag;
                        victimTag         <= tagArray[reqSet];
                        beat              <= '0;
                        mem_req           <= 1'b1;
                        validBits[reqSet] <= 1'b0;
                        if (validBits[reqSet] && dirtyBits[reqSet]) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= beatAddr(tagArray[reqSet], reqSet, '0);
                            mem_wdata <= wbData;
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= beatAddr(reqTag, reqSet, '0);
                        end
                    end
                end
                WB: begin
                    if (beatAck) begin
                        if (lastBeat) begin
                            state             <= FILL;
                            beat              <= '0;
                            dirtyBits[curSet] <= 1'b0;
                            mem_req           <= 1'b0;
                            mem_we            <= 1'b0;
                        end else begin
                            beat      <= beatNext;
                            mem_addr  <= beatAddr(victimTag, curSet, beatNext);
                            mem_wdata <= wbData;
                        end
                    end
                end
                FILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= beatAddr(curTag, curSet, '0);
                    end else if (mem_ack) begin
                        if (lastBeat) begin
                            state             <= DONE;
                            beat              <= '0;
                            mem_req           <= 1'b0;
                            validBits[curSet] <= 1'b1;
                        end else begin
                            beat     <= beatNext;
                            mem_addr <= beatAddr(curTag, curSet, beatNext);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a latency-configurable word memory model.
module tb_data_cache;

    logic        clk;
    logic        rstN;
    logic        rdReq;
    logic [3:0]  wrReq;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        miss;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    logic        zeroWait;
    logic        ackReg;
    logic [31:0] rdataReg;
    int          waitCnt;

    logic        logWe   [64];
    logic [31:0] logAddr [64];
    logic [31:0] logData [64];
    int          logCnt;

    int checkCount;
    int errorCount;

    data_cache dut (
        .CPU_CLK    (clk),
        .CPU_RST    (rstN),
        .rd_req     (rdReq),
        .wr_req     (wrReq),
        .addr       (addr),
        .wr_data    (wrData),
        .rd_data    (rdData),
        .miss       (miss),
        .mem_req    (memReq),
        .mem_we     (memWe),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_rdata  (memRdata),
        .mem_ack    (memAck),
        .hit_count  (hitCount),
        .miss_count (missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: every word holds its own byte address
    assign memAck   = zeroWait ? memReq : ackReg;
    assign memRdata = zeroWait ? memAddr : rdataReg;

    // Two-cycle acknowledge, one-cycle ack pulse
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ackReg   <= 1'b0;
            waitCnt  <= 0;
            rdataReg <= '0;
        end else if (ackReg) begin
            ackReg  <= 1'b0;
            waitCnt <= 0;
        end else if (memReq && !zeroWait) begin
            if (waitCnt == 1) begin
                ackReg   <= 1'b1;
                rdataReg <= memAddr;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end
    end

    // Record every completed beat
    always @(posedge clk) begin
        if (rstN && memReq && memAck && logCnt < 64) begin
            logWe[logCnt]   <= memWe;
            logAddr[logCnt] <= memAddr;
            logData[logCnt] <= memWe ? memWdata : memRdata;
            logCnt          <= logCnt + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge and hold it until miss clears
    task automatic startAccess(input logic rd, input logic [3:0] we, input logic [31:0] a,
                               input logic [31:0] d, output int cycles);
        int n;
        @(negedge clk);
        rdReq  = rd;
        wrReq  = we;
        addr   = a;
        wrData = d;
        #1;
        n = 0;
        while (miss === 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        cycles = n;
        checkVal("wait_miss_clear", {31'd0, miss}, 32'd0);
    endtask

    // Let the completing hit clock in, then drop the request
    task automatic endAccess();
        @(posedge clk);
        @(negedge clk);
        rdReq  = 1'b0;
        wrReq  = 4'b0000;
        addr   = '0;
        wrData = '0;
    endtask

    initial begin
        int cycles;
        int n;
        int base;
        checkCount = 0;
        errorCount = 0;
        logCnt     = 0;
        zeroWait   = 1'b0;
        rdReq      = 1'b0;
        wrReq      = 4'b0000;
        addr       = '0;
        wrData     = '0;
        rstN       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_mem_req", {31'd0, memReq}, 32'd0);
        checkVal("rst_mem_addr", memAddr, 32'd0);
        checkVal("rst_hit_count", hitCount, 32'd0);
        checkVal("rst_miss_count", missCount, 32'd0);
        checkVal("rst_miss_idle", {31'd0, miss}, 32'd0);
        rstN = 1'b1;

        // Cold load: 8 read beats from 0x1000, no write-back
        startAccess(1'b1, 4'b0000, 32'h0000_1004, 32'h0, cycles);
        checkVal("cold_rd_data", rdData, 32'h0000_1004);
        checkVal("cold_miss_count", missCount, 32'd1);
        checkVal("cold_beats", logCnt, 32'd8);
        for (int k = 0; k < 8; k++) begin
            checkVal("cold_beat_we", {31'd0, logWe[k]}, 32'd0);
            checkVal("cold_beat_addr", logAddr[k], 32'h0000_1000 + 32'(4 * k));
        end
        endAccess();
        checkVal("cold_hit_count", hitCount, 32'd1);

        // Same-line load hits immediately without memory traffic
        startAccess(1'b1, 4'b0000, 32'h0000_1010, 32'h0, cycles);
        checkVal("hit_latency", cycles, 32'd0);
        checkVal("hit_rd_data", rdData, 32'h0000_1010);
        checkVal("hit_mem_req", {31'd0, memReq}, 32'd0);
        endAccess();
        checkVal("hit_hit_count", hitCount, 32'd2);

        // Byte store into lane 1, then read it back
        startAccess(1'b0, 4'b0010, 32'h0000_1004, 32'h0000_AB00, cycles);
        checkVal("store_latency", cycles, 32'd0);
        endAccess();
        startAccess(1'b1, 4'b0000, 32'h0000_1004, 32'h0, cycles);
        checkVal("store_rd_data", rdData, 32'h0000_AB04);
        endAccess();
        checkVal("store_no_traffic", logCnt, 32'd8);
        checkVal("store_hit_count", hitCount, 32'd4);

        // Conflict miss evicts the dirty line before refilling
        startAccess(1'b1, 4'b0000, 32'h0000_2004, 32'h0, cycles);
        checkVal("evict_rd_data", rdData, 32'h0000_2004);
        checkVal("evict_miss_count", missCount, 32'd2);
        checkVal("evict_beats", logCnt, 32'd24);
        for (int k = 0; k < 8; k++) begin
            checkVal("wb_beat_we", {31'd0, logWe[8+k]}, 32'd1);
            checkVal("wb_beat_addr", logAddr[8+k], 32'h0000_1000 + 32'(4 * k));
            checkVal("wb_beat_data", logData[8+k],
                     (k == 1) ? 32'h0000_AB04 : 32'h0000_1000 + 32'(4 * k));
            checkVal("refill_beat_we", {31'd0, logWe[16+k]}, 32'd0);
            checkVal("refill_beat_addr", logAddr[16+k], 32'h0000_2000 + 32'(4 * k));
        end
        endAccess();

        // Reset while the fourth fill beat is outstanding
        @(negedge clk);
        rdReq = 1'b1;
        addr  = 32'h0000_3008;
        n = 0;
        while (logCnt < 27 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("reset_reach_beat3", logCnt, 32'd27);
        rstN = 1'b0;
        #1;
        checkVal("reset_mem_req", {31'd0, memReq}, 32'd0);
        checkVal("reset_miss_count", missCount, 32'd0);
        checkVal("reset_hit_count", hitCount, 32'd0);
        checkVal("reset_miss_active", {31'd0, miss}, 32'd1);
        base = logCnt;
        @(negedge clk);
        rstN = 1'b1;
        startAccess(1'b1, 4'b0000, 32'h0000_3008, 32'h0, cycles);
        checkVal("rerun_first_beat", logAddr[base], 32'h0000_3000);
        checkVal("rerun_beats", logCnt - base, 32'd8);
        checkVal("rerun_rd_data", rdData, 32'h0000_3008);
        checkVal("rerun_miss_count", missCount, 32'd1);
        endAccess();
        checkVal("rerun_hit_count", hitCount, 32'd1);

        // Zero-wait memory: miss held for exactly ten cycles on a clean refill
        zeroWait = 1'b1;
        base = logCnt;
        startAccess(1'b1, 4'b0000, 32'h0000_4000, 32'h0, cycles);
        checkVal("zw_miss_cycles", cycles, 32'd10);
        checkVal("zw_rd_data", rdData, 32'h0000_4000);
        checkVal("zw_beats", logCnt - base, 32'd8);
        checkVal("zw_miss_count", missCount, 32'd2);
        endAccess();
        checkVal("zw_hit_count", hitCount, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM-WB stage's data access and an external word-wide main memory.
- Replaces the stage's local data RAM as the source of load data and the sink of stores.
- Drives `DCacheMiss` into the hazard unit, which then stalls the pipeline until the access completes.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (8 words/line).
- SET_ADDR_LEN, 4, log2 of number of lines (16 lines).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN (=23), derived tag width. Not overridable.

Ports:
- CPU_CLK  in  1  clock; all state updates on its rising edge.
- CPU_RST  in  1  asynchronous, active-low reset.
- rd_req  in  1  load request this cycle.
- wr_req  in  4  store byte enables; nonzero means store request.
- addr  in  32  byte address; bits [1:0] are ignored for the word select.
- wr_data  in  32  store data, already lane-aligned.
- rd_data  out  32  full word at addr. Valid when a request is active and miss=0.
- miss  out  1  request not yet satisfiable; drives `DCacheMiss`.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  write-beat data.
- mem_rdata  in  32  read-beat data, valid with mem_ack.
- mem_ack  in  1  one-cycle beat completion.
- hit_count  out  32  number of completed hits.
- miss_count  out  32  number of misses entered.

Behaviour:
- Address split: offset = addr[LINE_ADDR_LEN+1:2]; set = next SET_ADDR_LEN bits; tag = remaining upper bits.
- Request active = rd_req | (|wr_req). If both rd_req and wr_req are set, the access is treated as a store.
- Hit = valid[set] & tag match & state IDLE.
- miss = active & ~hit, combinational. It is also forced to 1 whenever state != IDLE.
- rd_data is combinational from the line array: zero added latency on a hit.
- Store hit: on the clock edge, merge wr_data under the byte enables into the word and set dirty[set]. A no-write-enable cycle leaves the line unchanged.
- hit_count increments on each cycle with active & hit. miss_count increments on each IDLE->WB or IDLE->FILL transition. Both counters wrap at 2^32.
- State machine:
  - IDLE: on an active miss, go to WB if the victim is valid & dirty, else go to FILL. Latch the victim tag and the request set; clear the beat counter.
  - WB: mem_req=1, mem_we=1, mem_addr={victim tag, set, beat, 2'b00}, mem_wdata = line word[beat]. On mem_ack, beat++. On the ack of the last beat, go to FILL, beat=0, dirty cleared.
  - FILL: mem_req=1, mem_we=0, mem_addr={request tag, set, beat, 2'b00}. On mem_ack, write mem_rdata into word[beat], beat++. On the last ack, set valid and tag, and go to DONE.
  - DONE: one bubble cycle, with miss still 1. Then go to IDLE. The held request now hits and completes (a store merges and sets dirty).
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - mem_req drops to 0 for at least the cycle after the last beat of each phase.
  - mem_ack while mem_req=0 is ignored.
  - Beats are strictly in order, words 0..N-1.
- CPU requirement: the pipeline holds addr, rd_req, wr_req and wr_data stable while miss=1. A request change mid-refill does not abort the refill.
- Reset (asynchronous, at any time including mid-WB/FILL):
  - state=IDLE, beat=0, all valid=0, all dirty=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit_count=0, miss_count=0.
  - miss and rd_data are combinational: miss=active, rd_data = array contents (don't-care).
  - Dirty data in flight is lost.
- Memory with zero-wait acks (ack in the same cycle as req) is legal. Refill then costs N beats + 1 + 1 cycles per phase.

Decomposition:
- Shared package `cache_pkg`: state enum (IDLE, WB, FILL, DONE), and address-split localparams/functions (offset, set and tag extraction, beat-address build).
- One sub-module, `dcache_line_store`: line data array with byte-enable word write, full-word fill write, and combinational word read.
- Tag, valid and dirty state plus the FSM stay in data_cache.

Test Plan:
- Cold load addr=0x0000_1004, memory word k = 0x1000+4k, ack latency 2 -> miss=1, 8 read beats at addresses 0x1000..0x101C, no WB; then rd_data=0x1004, miss=0, miss_count=1.
- After the above, load 0x1010 -> hit in the same cycle, rd_data=0x1010, hit_count increments, mem_req stays 0.
- Store wr_req=4'b0010, wr_data=0x0000_AB00 to 0x1004, then load 0x1004 -> rd_data=0x0000_AB04; line dirty; no memory traffic.
- Load 0x2004 (same set, different tag) after the dirty store -> 8 write beats to 0x1000..0x101C with word 1 = 0x0000_AB04, then 8 read beats from 0x2000, then hit; miss_count=2.
- Assert CPU_RST low during beat 3 of FILL -> mem_req=0 immediately; after release, a load to the same address misses again with beat 0 restarted and miss_count restarted from 0.
- Zero-wait memory (mem_ack tied to mem_req) -> clean refill completes in 10 cycles (8 beats, mem_req gap, DONE), and miss deasserts on the 11th cycle.
